// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem requests, loads IF/ID, stops on HLT.
// Optional FETCH_PERF_EN macro adds saturating fetched/bubble performance counters.
module fetch_unit #(
    parameter int              N        = 64,
    parameter logic [N-1:0]    RESET_PC = '0,
    parameter int              INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [N-1:0]       redirect_pc_i,
    output logic               imem_req_o,
    output logic [N-1:0]       imem_addr_o,
    input  logic               imem_ready_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic               ifid_valid_o,
    output logic [N-1:0]       ifid_pc_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
`ifdef FETCH_PERF_EN
    output logic [31:0]        perf_fetched_o,
    output logic [31:0]        perf_bubble_o,
`endif
    output logic               halted_o
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [N-1:0]   pc;
    logic [N-1:0]   redirect_target;
    logic           accept;
    logic           is_hlt;
    logic           unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc_i[N-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
    assign accept               = imem_req_o && imem_ready_i;
    // HLT #imm16: only the opcode bits and the low fixed field are significant.
    assign is_hlt = (imem_data_i & INSTR_W'(32'hFFE0001F)) == INSTR_W'(32'hD4400000);
    assign imem_addr_o = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            BOOT:    next_state = RUN;
            RUN:     if (accept && is_hlt) next_state = HALTED;
            HALTED:  if (redirect_i) next_state = RUN;
            default: next_state = BOOT;
        endcase
    end

    always_comb begin
        imem_req_o = (state == RUN) && !stall_i && !redirect_i;
        halted_o   = (state == HALTED);
    end

    // Redirect beats stall beats fetch; an unaccepted, unstalled cycle drains IF/ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            ifid_valid_o <= 1'b0;
            ifid_pc_o    <= '0;
            ifid_instr_o <= '0;
        end else if (redirect_i) begin
            pc           <= redirect_target;
            ifid_valid_o <= 1'b0;
        end else if (accept) begin
            pc           <= pc + N'(4);
            ifid_valid_o <= 1'b1;
            ifid_pc_o    <= pc;
            ifid_instr_o <= imem_data_i;
        end else if (!stall_i) begin
            ifid_valid_o <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_o <= '0;
            perf_bubble_o  <= '0;
        end else begin
            if (accept && perf_fetched_o != 32'hFFFFFFFF) begin
                perf_fetched_o <= perf_fetched_o + 32'd1;
            end
            if (imem_req_o && !imem_ready_i && perf_bubble_o != 32'hFFFFFFFF) begin
                perf_bubble_o <= perf_bubble_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the ARMv8 pipeline.
- Owns the PC register, issues instruction-memory requests, and tolerates memory wait states.
- Loads the IF/ID pipeline register consumed by decode.
- Handles stall, branch redirect and HLT detection.

Parameters:
- N, 64, PC / address width in bits.
- RESET_PC, 64'h0, PC value loaded on reset.
- INSTR_W, 32, instruction width in bits (fixed at 32 for A64).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall_i  in  1  decode cannot accept; hold PC and IF/ID
- redirect_i  in  1  branch taken; load redirect_pc_i and squash IF/ID
- redirect_pc_i  in  N  branch target
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  N  fetch address (= PC, combinational)
- imem_ready_i  in  1  memory returns imem_data_i this cycle for imem_addr_o
- imem_data_i  in  INSTR_W  fetched instruction
- ifid_valid_o  out  1  IF/ID holds a live instruction
- ifid_pc_o  out  N  PC of IF/ID instruction
- ifid_instr_o  out  INSTR_W  IF/ID instruction
- halted_o  out  1  fetch stopped after HLT

Behaviour:
- Reset (sync, high):
  - pc=RESET_PC, state=BOOT.
  - ifid_valid_o=0, ifid_pc_o=0, ifid_instr_o=0, halted_o=0.
  - Reset overrides every other input in the same cycle, including mid-wait or mid-stall.
- imem_req_o = (state==RUN) && !stall_i && !redirect_i; imem_addr_o = pc always.
- A fetch is accepted when imem_req_o && imem_ready_i.
- FSM states:
  - BOOT: one idle cycle after reset; no request; next state RUN.
  - RUN: normal fetch.
  - HALTED: no requests; halted_o=1.
- Per-cycle priority in RUN, highest first:
  1. redirect_i: pc <= {redirect_pc_i[N-1:2],2'b00}; ifid_valid_o <= 0; IF/ID pc/instr hold. Applies even if stall_i=1. Any data returned that cycle is discarded.
  2. stall_i: pc and the whole IF/ID register hold.
  3. Accepted fetch: ifid <= {1, pc, imem_data_i}; pc <= pc+4 (mod 2^N, wraps silently).
  4. No acceptance (imem_ready_i=0): ifid_valid_o <= 0 (bubble); pc holds; request repeats next cycle at the same address.
- HLT detection: an accepted instruction with (instr & 32'hFFE0001F)==32'hD4400000:
  - Is still loaded into IF/ID with valid=1.
  - pc <= pc+4; state <= HALTED.
- HALTED:
  - ifid_valid_o <= 0 once decode consumes the HLT (first cycle with !stall_i); it holds while stalled.
  - redirect_i: state <= RUN, halted_o <= 0, pc loaded as in RUN priority 1.
  - Otherwise the state is sticky until reset.
- Redirect in BOOT: pc loaded, state still goes to RUN.
- Latency: accepted fetch at cycle t appears on ifid_* at t+1. Back-to-back fetches give one instruction per cycle.
- All ifid_* and halted_o outputs are registered. imem_addr_o and imem_req_o are combinational from registered state plus stall_i/redirect_i.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched_o[31:0] and perf_bubble_o[31:0], both 0 on reset.
  - perf_fetched_o increments on each accepted fetch.
  - perf_bubble_o increments on each RUN cycle with !stall_i, !redirect_i, !imem_ready_i.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then imem_ready_i=1 constant, data 32'h8B020020, 32'h8B020021, ... → cycle after reset no req; then ifid_pc_o = 0,4,8,12 with matching instr; ifid_valid_o=1 each cycle.
- imem_ready_i low for 3 cycles at pc=8 → imem_addr_o stays 8; ifid_valid_o=0 for 3 cycles; then pc 8 delivered, pc→12.
- stall_i=1 for 2 cycles with ifid_pc_o=4 → ifid_pc_o/instr/valid unchanged; imem_req_o=0; resume fetches pc=8 next.
- redirect_i=1, redirect_pc_i=64'h103 during stall_i=1 → next cycle pc=64'h100, ifid_valid_o=0; following cycle ifid_pc_o=64'h100.
- Fetch 32'hD4400000 at pc=16 → ifid shows HLT at 16 valid; halted_o=1; imem_req_o=0 thereafter; ifid_valid_o=0 next; redirect to 64'h40 resumes with halted_o=0.
- Assert reset during a 2-cycle memory wait at pc=64'h20 → next cycle pc=RESET_PC, ifid_valid_o=0, halted_o=0, state BOOT (no req for one cycle).
